// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared types and widths for the register-file writeback scheduler
package rf_sched_pkg;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {WB_NONE = 2'd0, WB_IEU = 2'd1, WB_LSU = 2'd2, WB_PC = 2'd3} wb_src_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bits for registers with a write in flight, x0 never busy
module rf_scoreboard
  import rf_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rs1_idx,
  input  logic [REG_AW-1:0] rs2_idx,
  input  logic [REG_AW-1:0] rd_idx,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_busy,
  output logic              clr_busy
);
  logic [31:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    // applied after the clear so a same-index set wins
    if (set_en) busy_d[set_idx] = 1'b1;
    busy_d[0] = 1'b0;
    rs1_busy = busy_q[rs1_idx];
    rs2_busy = busy_q[rs2_idx];
    rd_busy = busy_q[rd_idx];
    clr_busy = busy_q[clr_idx];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) busy_q <= '0;
    else busy_q <= busy_d;
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: issue hazard stall and IEU/LSU writeback arbitration for the
// register file's single write port, with starvation protection for the IEU
module rf_wb_sched
  import rf_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter bit LSU_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_uses_rs1,
  input  logic              issue_uses_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [1:0]        issue_wb_src,
  input  logic              ext_stall,
  output logic              issue_ready,
  input  logic              ieu_wb_valid,
  input  logic [REG_AW-1:0] ieu_wb_rd,
  input  logic              ieu_wb_pc,
  output logic              ieu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  output logic              lsu_wb_ready,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic              rf_wb_ieu,
  output logic              rf_wb_lsu,
  output logic              rf_wb_pc,
  output logic              rf_stall,
  output logic              wb_err
);
  logic rs1_busy, rs2_busy, rd_busy, clr_busy;
  logic haz, writes, set_en, g_ieu, g_lsu, wr;
  logic [REG_AW-1:0] g_rd;
  logic [3:0] starve_q, starve_d;
  logic wb_err_q, wb_err_d;
  rf_scoreboard u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (set_en),
    .set_idx  (issue_rd),
    .clr_en   (wr),
    .clr_idx  (g_rd),
    .rs1_idx  (issue_rs1),
    .rs2_idx  (issue_rs2),
    .rd_idx   (issue_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .clr_busy (clr_busy)
  );
  always_comb begin
    writes = wb_src_e'(issue_wb_src) != WB_NONE;
    haz = (issue_uses_rs1 & rs1_busy) | (issue_uses_rs2 & rs2_busy) | (writes & rd_busy);
    issue_ready = reset_n & ~haz & ~ext_stall;
    rf_stall = ~reset_n | ext_stall | (issue_valid & haz);
    set_en = issue_valid & issue_ready & writes & (issue_rd != '0);
    // writeback grants ignore stalls; reset_n gates them so nothing writes in reset
    g_ieu = reset_n & ieu_wb_valid & (~lsu_wb_valid | ~LSU_PRIO | (int'(starve_q) >= STARVE_LIMIT));
    g_lsu = reset_n & lsu_wb_valid & ~g_ieu;
    g_rd = g_ieu ? ieu_wb_rd : g_lsu ? lsu_wb_rd : '0;
    wr = (g_ieu | g_lsu) & (g_rd != '0);
    ieu_wb_ready = g_ieu;
    lsu_wb_ready = g_lsu;
    rf_rd_addr = g_rd;
    rf_wb_pc = wr & g_ieu & ieu_wb_pc;
    rf_wb_ieu = wr & g_ieu & ~ieu_wb_pc;
    rf_wb_lsu = wr & g_lsu;
    starve_d = g_ieu ? '0 : (ieu_wb_valid & (starve_q != 4'hf)) ? starve_q + 4'd1 : starve_q;
    wb_err_d = wb_err_q | (wr & ~clr_busy);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      starve_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      wb_err_q <= wb_err_d;
    end
  assign wb_err = wb_err_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed scenarios plus randomized traffic against a
// scoreboard model of the writeback scheduler
module tb_rf_wb_sched;
  import rf_sched_pkg::*;
  localparam int SL = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic issue_valid, issue_uses_rs1, issue_uses_rs2, ext_stall;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, ieu_wb_rd, lsu_wb_rd, rf_rd_addr;
  logic [1:0] issue_wb_src;
  logic issue_ready, ieu_wb_valid, ieu_wb_pc, ieu_wb_ready, lsu_wb_valid, lsu_wb_ready;
  logic rf_wb_ieu, rf_wb_lsu, rf_wb_pc, rf_stall, wb_err;
  int tests = 0, fails = 0;
  bit m_busy[32];
  int m_starve;
  bit m_err;
  bit e_ready, e_stall, e_gi, e_gl, e_ieu, e_lsu, e_pc;
  logic [4:0] e_rd;

  always #5 clk = ~clk;

  rf_wb_sched #(.STARVE_LIMIT(SL), .LSU_PRIO(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .issue_rd(issue_rd), .issue_wb_src(issue_wb_src), .ext_stall(ext_stall),
    .issue_ready(issue_ready), .ieu_wb_valid(ieu_wb_valid), .ieu_wb_rd(ieu_wb_rd),
    .ieu_wb_pc(ieu_wb_pc), .ieu_wb_ready(ieu_wb_ready), .lsu_wb_valid(lsu_wb_valid),
    .lsu_wb_rd(lsu_wb_rd), .lsu_wb_ready(lsu_wb_ready), .rf_rd_addr(rf_rd_addr),
    .rf_wb_ieu(rf_wb_ieu), .rf_wb_lsu(rf_wb_lsu), .rf_wb_pc(rf_wb_pc),
    .rf_stall(rf_stall), .wb_err(wb_err)
  );

  task automatic model_eval();
    bit haz;
    haz = (issue_uses_rs1 && issue_rs1 != 0 && m_busy[issue_rs1]) ||
          (issue_uses_rs2 && issue_rs2 != 0 && m_busy[issue_rs2]) ||
          (issue_wb_src != 2'd0 && issue_rd != 0 && m_busy[issue_rd]);
    e_ready = reset_n && !haz && !ext_stall;
    e_stall = !reset_n || ext_stall || (issue_valid && haz);
    e_gi = reset_n && ieu_wb_valid && (!lsu_wb_valid || m_starve >= SL);
    e_gl = reset_n && lsu_wb_valid && !e_gi;
    e_rd = e_gi ? ieu_wb_rd : e_gl ? lsu_wb_rd : 5'd0;
    e_pc = e_gi && ieu_wb_pc && e_rd != 0;
    e_ieu = e_gi && !ieu_wb_pc && e_rd != 0;
    e_lsu = e_gl && e_rd != 0;
  endtask

  task automatic model_update();
    bit set;
    if (!reset_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_starve = 0;
      m_err = 0;
      return;
    end
    set = issue_valid && e_ready && issue_wb_src != 2'd0 && issue_rd != 0;
    if (set && (e_gi || e_gl) && e_rd == issue_rd) begin
      fails++;
      $display("FAIL set_clear_same_index rd=%0d", issue_rd);
    end
    if ((e_gi || e_gl) && e_rd != 0) begin
      if (!m_busy[e_rd]) m_err = 1;
      m_busy[e_rd] = 0;
    end
    if (set) m_busy[issue_rd] = 1;
    if (e_gi) m_starve = 0;
    else if (ieu_wb_valid && m_starve < 15) m_starve++;
  endtask

  task automatic tick();
    model_eval();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
    issue_rd = 0; issue_wb_src = 2'd0; ext_stall = 0;
    ieu_wb_valid = 0; ieu_wb_rd = 0; ieu_wb_pc = 0; lsu_wb_valid = 0; lsu_wb_rd = 0;
  endtask

  task automatic test_reset();
    idle();
    issue_valid = 1; issue_rd = 4; issue_wb_src = 2'd1;
    ieu_wb_valid = 1; ieu_wb_rd = 3; lsu_wb_valid = 1; lsu_wb_rd = 4;
    #1;
    tests++;
    if ({issue_ready, ieu_wb_ready, lsu_wb_ready, rf_wb_ieu, rf_wb_lsu, rf_wb_pc, rf_rd_addr, rf_stall, wb_err} !== 13'b0000000000010) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b ieu=%b lsu=%b wb=%b%b%b addr=%0d stall=%b err=%b", issue_ready,
               ieu_wb_ready, lsu_wb_ready, rf_wb_ieu, rf_wb_lsu, rf_wb_pc, rf_rd_addr, rf_stall, wb_err);
    end
    tick();
    reset_n = 1;
    idle();
    #1;
    tests++;
    if ({issue_ready, rf_stall} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release got ready=%b stall=%b exp 1 0", issue_ready, rf_stall);
    end
  endtask

  task automatic test_raw();
    idle(); issue_valid = 1; issue_rd = 5; issue_wb_src = 2'd2;
    tick();
    for (int c = 0; c < 2; c++) begin
      idle(); issue_valid = 1; issue_rs1 = 5; issue_uses_rs1 = 1;
      #1;
      tests++;
      if ({issue_ready, rf_stall} !== 2'b01) begin
        fails++;
        $display("FAIL raw_stall c=%0d got ready=%b stall=%b exp 0 1", c, issue_ready, rf_stall);
      end
      tick();
    end
    lsu_wb_valid = 1; lsu_wb_rd = 5;
    #1;
    tests++;
    if ({issue_ready, lsu_wb_ready, rf_wb_lsu, rf_rd_addr} !== {3'b011, 5'd5}) begin
      fails++;
      $display("FAIL raw_grant got ready=%b lrdy=%b wb_lsu=%b addr=%0d exp 0 1 1 5", issue_ready, lsu_wb_ready, rf_wb_lsu, rf_rd_addr);
    end
    tick();
    lsu_wb_valid = 0;
    #1;
    tests++;
    if ({issue_ready, rf_stall} !== 2'b10) begin
      fails++;
      $display("FAIL raw_release got ready=%b stall=%b exp 1 0", issue_ready, rf_stall);
    end
    tick();
  endtask

  task automatic test_x0();
    idle(); issue_valid = 1; issue_rd = 0; issue_wb_src = 2'd1;
    tick();
    idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 0; issue_rd = 0; issue_wb_src = 2'd1;
    ieu_wb_valid = 1; ieu_wb_rd = 0;
    #1;
    tests++;
    if ({issue_ready, ieu_wb_ready, rf_wb_ieu, rf_wb_lsu, rf_wb_pc, rf_rd_addr} !== {5'b11000, 5'd0}) begin
      fails++;
      $display("FAIL x0_write got ready=%b irdy=%b wb=%b%b%b addr=%0d exp 1 1 000 0", issue_ready, ieu_wb_ready,
               rf_wb_ieu, rf_wb_lsu, rf_wb_pc, rf_rd_addr);
    end
    tick();
    idle();
    #1;
    tests++;
    if (wb_err !== 1'b0) begin
      fails++;
      $display("FAIL x0_no_err got %b exp 0", wb_err);
    end
  endtask

  task automatic test_starve();
    for (int c = 0; c < 7; c++) begin
      idle(); ieu_wb_valid = 1; lsu_wb_valid = 1;
      #1;
      tests++;
      if ({ieu_wb_ready, lsu_wb_ready} !== {c == 4, c != 4}) begin
        fails++;
        $display("FAIL starve_c%0d got ieu=%b lsu=%b exp %b %b", c, ieu_wb_ready, lsu_wb_ready, c == 4, c != 4);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_pc();
    idle(); issue_valid = 1; issue_rd = 1; issue_wb_src = 2'd3;
    tick();
    idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 1;
    ieu_wb_valid = 1; ieu_wb_pc = 1; ieu_wb_rd = 1;
    #1;
    tests++;
    if ({issue_ready, ieu_wb_ready, rf_wb_pc, rf_wb_ieu, rf_wb_lsu, rf_rd_addr} !== {5'b01100, 5'd1}) begin
      fails++;
      $display("FAIL pc_grant got ready=%b irdy=%b pc=%b ieu=%b lsu=%b addr=%0d exp 0 1 1 0 0 1", issue_ready,
               ieu_wb_ready, rf_wb_pc, rf_wb_ieu, rf_wb_lsu, rf_rd_addr);
    end
    tick();
    ieu_wb_valid = 0; ieu_wb_pc = 0;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL pc_clear got ready=%b exp 1", issue_ready);
    end
    tick();
  endtask

  task automatic test_waw_ext();
    idle(); issue_valid = 1; issue_rd = 9; issue_wb_src = 2'd2;
    tick();
    idle(); issue_valid = 1; issue_rd = 9; issue_wb_src = 2'd1;
    #1;
    tests++;
    if ({issue_ready, rf_stall} !== 2'b01) begin
      fails++;
      $display("FAIL waw_stall got ready=%b stall=%b exp 0 1", issue_ready, rf_stall);
    end
    tick();
    idle(); ext_stall = 1; issue_valid = 1; issue_rd = 10; issue_wb_src = 2'd1;
    lsu_wb_valid = 1; lsu_wb_rd = 9;
    #1;
    tests++;
    if ({issue_ready, rf_stall, lsu_wb_ready, rf_wb_lsu, rf_rd_addr} !== {4'b0111, 5'd9}) begin
      fails++;
      $display("FAIL ext_stall got ready=%b stall=%b lrdy=%b wb_lsu=%b addr=%0d exp 0 1 1 1 9", issue_ready, rf_stall,
               lsu_wb_ready, rf_wb_lsu, rf_rd_addr);
    end
    tick();
    idle(); issue_rd = 9; issue_wb_src = 2'd1;
    #1;
    tests++;
    if (issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL waw_cleared got ready=%b exp 1", issue_ready);
    end
    tick();
  endtask

  task automatic test_random();
    int bl[$];
    logic [12:0] got, exp;
    for (int n = 0; n < 300; n++) begin
      bl = {};
      for (int i = 1; i < 32; i++) if (m_busy[i]) bl.push_back(i);
      issue_valid = 1'($urandom_range(0, 1));
      issue_rs1 = 5'($urandom_range(0, 31)); issue_rs2 = 5'($urandom_range(0, 31));
      issue_uses_rs1 = 1'($urandom_range(0, 1)); issue_uses_rs2 = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 31)); issue_wb_src = 2'($urandom_range(0, 3));
      ext_stall = $urandom_range(0, 3) == 0;
      ieu_wb_valid = $urandom_range(0, 2) != 0; ieu_wb_pc = 1'($urandom_range(0, 1));
      ieu_wb_rd = bl.size() == 0 ? 5'd0 : 5'(bl[$urandom_range(0, bl.size() - 1)]);
      lsu_wb_valid = $urandom_range(0, 2) != 0;
      lsu_wb_rd = bl.size() == 0 ? 5'd0 : 5'(bl[$urandom_range(0, bl.size() - 1)]);
      #1;
      model_eval();
      got = {issue_ready, rf_stall, ieu_wb_ready, lsu_wb_ready, rf_rd_addr, rf_wb_ieu, rf_wb_lsu, rf_wb_pc, wb_err};
      exp = {e_ready, e_stall, e_gi, e_gl, e_rd, e_ieu, e_lsu, e_pc, m_err};
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL random_n%0d got %b exp %b", n, got, exp);
      end
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      bl = {};
      for (int i = 1; i < 32; i++) if (m_busy[i]) bl.push_back(i);
      idle();
      if (bl.size() == 0) break;
      lsu_wb_valid = 1; lsu_wb_rd = 5'(bl[0]);
      tick();
    end
    idle();
  endtask

  task automatic test_err();
    idle(); lsu_wb_valid = 1; lsu_wb_rd = 7;
    #1;
    tests++;
    if ({lsu_wb_ready, wb_err} !== 2'b10) begin
      fails++;
      $display("FAIL err_grant got lrdy=%b err=%b exp 1 0", lsu_wb_ready, wb_err);
    end
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (wb_err !== 1'b1) begin
        fails++;
        $display("FAIL err_sticky c=%0d got %b exp 1", c, wb_err);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle(); issue_valid = 1; issue_rd = 3; issue_wb_src = 2'd1;
    tick();
    idle(); issue_valid = 1; issue_uses_rs1 = 1; issue_rs1 = 3;
    #1;
    tests++;
    if (issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_busy got ready=%b exp 0", issue_ready);
    end
    #1 reset_n = 0;
    #1;
    tests++;
    if ({issue_ready, rf_stall, wb_err} !== 3'b010) begin
      fails++;
      $display("FAIL mid_reset got ready=%b stall=%b err=%b exp 0 1 0", issue_ready, rf_stall, wb_err);
    end
    tick();
    reset_n = 1;
    #1;
    tests++;
    if ({issue_ready, rf_stall, wb_err} !== 3'b100) begin
      fails++;
      $display("FAIL mid_after got ready=%b stall=%b err=%b exp 1 0 0", issue_ready, rf_stall, wb_err);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0();
    test_starve();
    test_pc();
    test_waw_ext();
    test_random();
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Control-only scheduler for the register file's single write port and its read-hazard stall.
- Holds a 31-entry busy scoreboard for destination registers with writes in flight. Stalls the issue stage on RAW/WAW hazards and drives the register file's `rd_addr`, `wb_ieu`, `wb_lsu`, `wb_pc` and `stall`.
- Arbitrates between the IEU and LSU writeback requesters with starvation protection.
- Data is not routed through this block; the register file muxes write data itself.

Parameters:
- STARVE_LIMIT, 4: consecutive IEU losses after which the IEU gets priority over the LSU (range 1..15).
- LSU_PRIO, 1: 1 = LSU wins ties by default; 0 = IEU wins ties by default.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction in decode wants to issue.
- issue_rs1  in  5  source 1 index.
- issue_rs2  in  5  source 2 index.
- issue_uses_rs1  in  1  instruction reads rs1.
- issue_uses_rs2  in  1  instruction reads rs2.
- issue_rd  in  5  destination index.
- issue_wb_src  in  2  wb_src_e of the pending write (NONE/IEU/LSU/PC).
- ext_stall  in  1  downstream back-pressure.
- issue_ready  out  1  issue accepted this cycle when high with issue_valid.
- ieu_wb_valid  in  1  IEU result ready to write.
- ieu_wb_rd  in  5  IEU destination.
- ieu_wb_pc  in  1  write inc_pc instead of ieu_result.
- ieu_wb_ready  out  1  IEU write granted this cycle.
- lsu_wb_valid  in  1  load data ready to write.
- lsu_wb_rd  in  5  LSU destination.
- lsu_wb_ready  out  1  LSU write granted this cycle.
- rf_rd_addr  out  5  to register file `rd_addr`.
- rf_wb_ieu  out  1  to register file `wb_ieu`.
- rf_wb_lsu  out  1  to register file `wb_lsu`.
- rf_wb_pc  out  1  to register file `wb_pc`.
- rf_stall  out  1  to register file `stall`.
- wb_err  out  1  sticky: write granted to a non-busy register.

Behaviour:
- State:
  - busy[31:1] flops; index 0 is hardwired not busy.
  - starve_cnt, 4-bit saturating counter.
  - wb_err flop.
  - All of these clear asynchronously on reset_n low.
- Outputs while reset_n is low: issue_ready=0, both wb readies=0, all rf_wb_*=0, rf_rd_addr=0, rf_stall=1, wb_err=0.
- Hazard (combinational, from registered busy only):
  - haz = (issue_uses_rs1 & busy[issue_rs1]) | (issue_uses_rs2 & busy[issue_rs2]) | (issue_wb_src!=NONE & busy[issue_rd]).
  - Index 0 never hazards.
- Stall outputs:
  - issue_ready = !haz & !ext_stall.
  - rf_stall = ext_stall | (issue_valid & haz).
- Issue fire (issue_valid & issue_ready) with wb_src!=NONE and rd!=0 sets busy[rd] at the next edge. wb_src=NONE or rd=0 leaves the scoreboard unchanged.
- Arbitration (combinational; one grant per cycle):
  - Only one requester valid: it is granted.
  - Both valid: IEU is granted if starve_cnt>=STARVE_LIMIT; otherwise the LSU_PRIO default winner is granted.
- starve_cnt:
  - +1, saturating at 15, when the IEU is valid and loses.
  - Cleared when the IEU is granted.
  - Otherwise held.
- Grant outputs, same cycle as the grant:
  - ieu_wb_ready/lsu_wb_ready assert for the granted requester only.
  - rf_rd_addr = granted rd; with no grant, rf_rd_addr = 0.
  - IEU grant: rf_wb_pc=ieu_wb_pc, rf_wb_ieu=!ieu_wb_pc.
  - LSU grant: rf_wb_lsu=1.
  - At most one rf_wb_* is high in any cycle.
  - Granted rd=0: ready still asserts, rf_wb_* stay 0, no scoreboard change.
- Writeback clears busy[granted rd] at the next edge. The register file writes at that same edge, so a dependent instruction issues one cycle after the grant cycle and reads the new value.
- If busy[granted rd] is already 0 (rd!=0), wb_err sets and stays set until reset.
- Set and clear of the same index in the same cycle cannot occur: an issue to a busy rd stalls on WAW. The bench asserts this; if it does occur, set wins.
- Stall interaction:
  - Writeback grants ignore ext_stall and hazards.
  - Scoreboard clears happen during stalls.
- Reset mid-operation discards all pending state; upstream is reset too.

Decomposition:
- rf_sched_pkg:
  - wb_src_e enum: WB_NONE=0, WB_IEU=1, WB_LSU=2, WB_PC=3.
  - REG_AW=5.
- One sub-module, rf_scoreboard:
  - Holds busy[31:1] with set/clear ports.
  - Provides three combinational lookup ports (rs1, rs2, rd).
- The arbiter, starve counter and output muxing stay in rf_wb_sched.

Test Plan:
- RAW hazard:
  - Issue rd=5, wb_src=LSU → busy[5]=1 next cycle.
  - Next issue, rs1=5 uses_rs1 → issue_ready=0, rf_stall=1 until the cycle after lsu_wb_valid with rd=5 is granted; then issue_ready=1.
- x0 handling:
  - Issue rd=0, wb_src=IEU → no busy bit set.
  - ieu_wb rd=0 → ieu_wb_ready=1, all rf_wb_*=0, wb_err=0.
- Priority and starvation (LSU_PRIO=1, STARVE_LIMIT=4):
  - IEU and LSU both valid every cycle for 6 cycles → LSU granted cycles 0–3, IEU cycle 4, LSU cycle 5.
  - starve_cnt returns to 0 after cycle 4.
- PC writeback: ieu_wb_valid, ieu_wb_pc=1, rd=1 → rf_wb_pc=1, rf_wb_ieu=0, rf_rd_addr=1, busy[1] cleared next cycle.
- Error and reset:
  - lsu_wb to non-busy rd=7 → wb_err=1 and sticky.
  - Assert reset_n low mid-cycle with busy[3]=1 → busy cleared immediately, wb_err=0, issue_ready=0 during reset.
- WAW and ext_stall:
  - With busy[9]=1, issue rd=9 → stalls.
  - ext_stall=1 with no hazard → issue_ready=0, rf_stall=1, and a concurrent LSU write is still granted.
